// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite slave register file: NUM_REGS x 32-bit words, byte strobes, one-cycle reads.
// Optional macro AXIL_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi_lite_slave_regfile #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int WRD_W = ADDR_W - 2;
    localparam int NB    = DATA_W / 8;
    localparam logic [WRD_W-1:0] REG_LIM = WRD_W'(NUM_REGS);
    localparam logic [1:0] RESP_OK = 2'b00;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    logic              aw_held;
    logic              w_held;
    logic [WRD_W-1:0]  aw_word;
    logic [DATA_W-1:0] w_data;
    logic [NB-1:0]     w_strb;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic             commit;
    logic             wr_hit;
    logic             rd_hit;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             unused_ok;

    assign awready = !aw_held;
    assign wready  = !w_held;
    assign arready = !rvalid;

    // Commit waits for a free response slot so a queued write is never lost.
    assign commit = aw_held && w_held && !bvalid;
    assign wr_hit = aw_word < REG_LIM;
    assign rd_hit = araddr[ADDR_W-1:2] < REG_LIM;
    assign wr_idx = aw_word[IDX_W-1:0];
    assign rd_idx = araddr[IDX_W+1:2];

    assign unused_ok = ^{awaddr[1:0], araddr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_word <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OK;
        end else begin
            if (awvalid && !aw_held) begin
                aw_held <= 1'b1;
                aw_word <= awaddr[ADDR_W-1:2];
            end else if (commit) begin
                aw_held <= 1'b0;
            end
            if (wvalid && !w_held) begin
                w_held <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end else if (commit) begin
                w_held <= 1'b0;
            end
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= wr_hit ? RESP_OK : RESP_OOR;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Reads sample regs before the same-edge write lands, returning the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OK;
        end else begin
            if (commit && wr_hit) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_strb[b]) regs[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
            if (arvalid && !rvalid) begin
                rvalid <= 1'b1;
                rdata  <= rd_hit ? regs[rd_idx] : '0;
                rresp  <= rd_hit ? RESP_OK : RESP_OOR;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Directed bench for axi_lite_slave_regfile (NUM_REGS = 16).
// Expected values are hand-computed; inputs driven 1 ns after each rising edge.
module tb_axi_lite_slave_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;

    int total = 0;
    int bad = 0;

`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    axi_lite_slave_regfile #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(16)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [1:0] r,
                      output int lat);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 10) begin
            step();
            lat++;
        end
        check("wr_bvalid", 32'(bvalid), 32'd1);
        r = bresp;
        step();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d,
                      output logic [1:0] r);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        step();
        arvalid = 1'b0;
        check("rd_rvalid", 32'(rvalid), 32'd1);
        d = rdata;
        r = rresp;
        step();
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    int          pulses;

    initial begin
        #12;
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b1;
        step();

        // same-cycle AW/W, latency 1
        wr(32'h18, 32'hAABBCCDD, 4'hF, r, lat);
        check("w18_lat", 32'(lat), 32'd1);
        check("w18_bresp", 32'(r), 32'd0);
        rd(32'h18, d, r);
        check("r18_data", d, 32'hAABBCCDD);
        check("r18_rresp", 32'(r), 32'd0);

        // W two cycles ahead of AW
        bready = 1'b0;
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("wfirst_wready0", 32'(wready), 32'd0);
        step();
        check("wfirst_wready1", 32'(wready), 32'd0);
        check("wfirst_nob", 32'(bvalid), 32'd0);
        awaddr = 32'h04; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("wfirst_wready2", 32'(wready), 32'd0);
        check("wfirst_nob2", 32'(bvalid), 32'd0);
        step();
        check("wfirst_bvalid", 32'(bvalid), 32'd1);
        check("wfirst_wready3", 32'(wready), 32'd1);
        bready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (bvalid) pulses++;
            step();
        end
        check("wfirst_pulses", 32'(pulses), 32'd1);
        rd(32'h04, d, r);
        check("r04_data", d, 32'h12345678);

        // byte strobes
        wr(32'h08, 32'hFFFFFFFF, 4'hF, r, lat);
        wr(32'h08, 32'h00000000, 4'h5, r, lat);
        check("strb_bresp", 32'(r), 32'd0);
        rd(32'h08, d, r);
        check("strb_data", d, 32'hFF00FF00);

        // zero strobe
        wr(32'h08, 32'h12121212, 4'h0, r, lat);
        check("zstrb_bresp", 32'(r), 32'd0);
        rd(32'h08, d, r);
        check("zstrb_data", d, 32'hFF00FF00);

        // back-pressure with a second write queued
        bready = 1'b0;
        awaddr = 32'h0C; wdata = 32'h11111111; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        check("bp_b1", 32'(bvalid), 32'd1);
        awaddr = 32'h10; wdata = 32'h22222222;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_bvalid", 32'(bvalid), 32'd1);
            check("bp_hold_bresp", 32'(bresp), 32'd0);
            check("bp_hold_awready", 32'(awready), 32'd0);
            step();
        end
        rd(32'h10, d, r);
        check("bp_r10_stall", d, 32'd0);
        bready = 1'b1;
        step();
        check("bp_b_clear", 32'(bvalid), 32'd0);
        step();
        check("bp_b2", 32'(bvalid), 32'd1);
        step();
        check("bp_b2_clear", 32'(bvalid), 32'd0);
        rd(32'h0C, d, r);
        check("bp_r0c", d, 32'h11111111);
        rd(32'h10, d, r);
        check("bp_r10", d, 32'h22222222);

        // read and commit on the same edge
        awaddr = 32'h18; wdata = 32'h55667788; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h18; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        check("raw_rvalid", 32'(rvalid), 32'd1);
        check("raw_old", rdata, 32'hAABBCCDD);
        check("raw_bvalid", 32'(bvalid), 32'd1);
        step();
        rd(32'h18, d, r);
        check("raw_new", d, 32'h55667788);

        // out of range
        wr(32'h101, 32'hDEADBEEF, 4'hF, r, lat);
        check("oor_bresp", 32'(r), 32'(OOR));
        rd(32'h100, d, r);
        check("oor_rdata", d, 32'd0);
        check("oor_rresp", 32'(r), 32'(OOR));
        rd(32'h00, d, r);
        check("oor_reg0", d, 32'd0);
        rd(32'h3C, d, r);
        check("top_reg15", d, 32'd0);
        check("top_rresp", 32'(r), 32'd0);

        // reset with only AW held
        awaddr = 32'h14; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("prerst_awready", 32'(awready), 32'd0);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("post_awready", 32'(awready), 32'd1);
        check("post_wready", 32'(wready), 32'd1);
        check("post_arready", 32'(arready), 32'd1);
        check("post_bvalid", 32'(bvalid), 32'd0);
        wr(32'h1C, 32'hCAFEF00D, 4'hF, r, lat);
        check("post_first_lat", 32'(lat), 32'd1);
        rd(32'h18, d, r);
        check("post_r18", d, 32'd0);
        rd(32'h04, d, r);
        check("post_r04", d, 32'd0);
        rd(32'h1C, d, r);
        check("post_r1c", d, 32'hCAFEF00D);
        rd(32'h14, d, r);
        check("post_r14", d, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/axi_lite_slave_regfile.md
AXI_LITE_SLAVE_REGFILE -- requirements
Module: axi_lite_slave_regfile

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers (power of 2, 2..256).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports awaddr input ADDR_W, awvalid input 1, awready output 1  write-address channel.
REQ-007 SHALL have ports wdata input 32, wstrb input 4, wvalid input 1, wready output 1  write-data channel.
REQ-008 SHALL have ports bresp output 2, bvalid output 1, bready input 1  write-response channel.
REQ-009 SHALL have ports araddr input ADDR_W, arvalid input 1, arready output 1  read-address channel.
REQ-010 SHALL have ports rdata output 32, rresp output 2, rvalid output 1, rready input 1  read-data channel.

Function
REQ-011 SHALL index registers by word index = addr[log2(NUM_REGS)+1:2], ignoring addr[1:0]; the address is in range when addr[ADDR_W-1:2] < NUM_REGS.
REQ-012 SHALL drive awready = !aw_held and wready = !w_held; each is a registered holding flag.
REQ-013 SHALL latch the address and set aw_held on an AW handshake, and latch data/strobe and set w_held on a W handshake; AW and W accepted in either order or in the same cycle.
REQ-014 SHALL commit a write on the first edge where aw_held && w_held && !bvalid: update only the bytes enabled by wstrb, set bvalid, clear both held flags.
REQ-015 Write latency: with AW and W handshaken at edge T, bvalid SHALL be high after edge T+1.
REQ-016 SHALL hold bvalid and bresp stable until bready; bvalid clears on the edge where bvalid && bready.
REQ-017 While bvalid is high and both holding flags are set, commit SHALL stall; no second write is lost or reordered.
REQ-018 A write with wstrb = 4'b0000 SHALL still complete with OKAY and leave the register unchanged.
REQ-019 SHALL drive arready = !rvalid.
REQ-020 On an AR handshake at edge T, SHALL load rdata/rresp and set rvalid at that same edge (one-cycle read latency).
REQ-021 SHALL hold rdata, rresp and rvalid stable until rready; rvalid clears on the edge where rvalid && rready.
REQ-022 A read and a write commit to the same register on the same edge SHALL return the pre-write value.
REQ-023 Read and write channels SHALL operate fully independently and concurrently.
REQ-024 SHALL drive bresp/rresp = 2'b00 (OKAY) for in-range accesses.

Reset
REQ-025 While rst = 0, SHALL clear all registers to 0; bvalid, rvalid, aw_held and w_held to 0; bresp, rresp and rdata to 0. awready, wready and arready are therefore 1.
REQ-026 Reset asserted mid-transaction SHALL discard any held AW/W and any pending B/R response; no response is issued after release.
REQ-027 The first handshake SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-028 With macro AXIL_SLVERR_EN defined: an out-of-range write SHALL leave all registers unchanged and respond bresp = 2'b10; an out-of-range read SHALL respond rresp = 2'b10 with rdata = 0.
REQ-029 Without AXIL_SLVERR_EN: out-of-range writes SHALL be dropped with bresp = OKAY, and out-of-range reads SHALL return rdata = 0 with rresp = OKAY.

Verification
REQ-030 Write awaddr = 0x18, wdata = 0xAABBCCDD, wstrb = 0xF in the same cycle, bready = 1 -> bvalid one cycle later with bresp = 00; a read of 0x18 returns 0xAABBCCDD, rresp = 00.
REQ-031 W (0x12345678) two cycles before AW (0x04) -> wready low until commit; reg1 = 0x12345678; exactly one bvalid pulse.
REQ-032 reg2 = 0xFFFFFFFF, then write 0x08 with data 0x00000000 and wstrb = 0x5 -> a read of 0x08 returns 0xFF00FF00.
REQ-033 bready held low 5 cycles with a second AW/W queued -> bresp/bvalid stable, second commit only after the first B handshake, both registers updated.
REQ-034 With AXIL_SLVERR_EN, write 0x101 and read 0x100 (NUM_REGS = 16) -> bresp = 10, rresp = 10, rdata = 0, no register changed; without the macro, both respond 00.
REQ-035 Assert rst low while aw_held = 1 and w_held = 0 -> after release, no bvalid, all registers 0, awready = wready = arready = 1.
